// File: rtl/n2r_sched_ctrl.sv
// n2r_sched_ctrl: row-block fill / slice drain scheduler for an N-core MAC array.
// Rows of one row-block are written into a buffer, then the block is read back
// as slices of NUM_CORES chunks until every chunk of the block has been issued.
// Optional feature: define N2R_SCHED_STALL_CNT_EN to add the stall_cnt output.
module n2r_sched_ctrl #(
  parameter int ROW        = 2754,
  parameter int COL        = 256,
  parameter int BLOCK_SIZE = 2,
  parameter int NUM_CORES  = 8,
  localparam int CPR   = COL / BLOCK_SIZE,
  localparam int NBLK  = ROW / BLOCK_SIZE,
  localparam int WR_W  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1,
  localparam int CB_W  = (CPR > 1) ? $clog2(CPR) : 1,
  localparam int BLK_W = (NBLK > 1) ? $clog2(NBLK) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [WR_W-1:0]      wr_row,
  output logic                 slice_valid,
  input  logic                 slice_ready,
  output logic [CB_W-1:0]      chunk_base,
  output logic [NUM_CORES-1:0] core_mask,
  output logic [BLK_W-1:0]     blk_idx,
  output logic                 busy,
`ifdef N2R_SCHED_STALL_CNT_EN
  output logic [31:0]          stall_cnt,
`endif
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   slice_valid_q, slice_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_CORES-1:0]   core_mask_q, core_mask_d;
  logic [CB_W-1:0]        chunk_base_q, chunk_base_d;
  logic [WR_W-1:0]        wr_row_q, wr_row_d;
  logic [BLK_W-1:0]       blk_idx_q, blk_idx_d;
  logic [31:0]            base_step;
  logic [31:0]            next_base;
  logic                   slice_accept;

  // The write strobe is the only combinational output: a row lands when offered while accepted.
  assign wr_en        = in_valid & in_ready_q;
  assign slice_accept = slice_valid_q & slice_ready;

  // Next-state and counter logic; arithmetic is widened to 32 bits so the step past the
  // last chunk never wraps inside the narrow chunk_base register.
  always_comb begin
    state_d      = state_q;
    wr_row_d     = wr_row_q;
    chunk_base_d = chunk_base_q;
    blk_idx_d    = blk_idx_q;
    base_step    = 32'(chunk_base_q) + 32'(NUM_CORES);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FILL;
          wr_row_d     = '0;
          blk_idx_d    = '0;
          chunk_base_d = '0;
        end
      end
      FILL: begin
        if (wr_en) begin
          if (32'(wr_row_q) == 32'(BLOCK_SIZE - 1)) begin
            wr_row_d = '0;
            state_d  = DRAIN;
          end else begin
            wr_row_d = wr_row_q + WR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (slice_accept) begin
          if (base_step >= 32'(CPR)) begin
            chunk_base_d = '0;
            if (32'(blk_idx_q) == 32'(NBLK - 1)) begin
              state_d = DONE;
            end else begin
              state_d   = FILL;
              blk_idx_d = blk_idx_q + BLK_W'(1);
            end
          end else begin
            chunk_base_d = CB_W'(base_step);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the upcoming state so they line up with it.
  always_comb begin
    next_base     = 32'(chunk_base_d);
    in_ready_d    = (state_d == FILL);
    slice_valid_d = (state_d == DRAIN);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    core_mask_d   = '0;
    if (state_d == DRAIN) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        core_mask_d[i] = (next_base + 32'(i)) < 32'(CPR);
      end
    end
  end

  // State and output registers, cleared asynchronously so a reset abandons any matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      slice_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      core_mask_q   <= '0;
      chunk_base_q  <= '0;
      wr_row_q      <= '0;
      blk_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      slice_valid_q <= slice_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      core_mask_q   <= core_mask_d;
      chunk_base_q  <= chunk_base_d;
      wr_row_q      <= wr_row_d;
      blk_idx_q     <= blk_idx_d;
    end
  end

`ifdef N2R_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count drain cycles where the cores refuse the slice; cleared by a new matrix, saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && start) begin
      stall_cnt_d = '0;
    end else if (state_q == DRAIN && !slice_ready && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign in_ready    = in_ready_q;
  assign slice_valid = slice_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign core_mask   = core_mask_q;
  assign chunk_base  = chunk_base_q;
  assign wr_row      = wr_row_q;
  assign blk_idx     = blk_idx_q;

endmodule

// File: tb/tb_n2r_sched_ctrl.sv
// Testbench for n2r_sched_ctrl with a small matrix (CPR=3, SPB=2, NBLK=2).
// The reference model tracks the matrix as a queue of expected slices built from
// plain arithmetic and a phase per cycle; define N2R_SCHED_STALL_CNT_EN to check stall_cnt.
module tb_n2r_sched_ctrl;

  localparam int ROW  = 4;
  localparam int COL  = 6;
  localparam int BS   = 2;
  localparam int NC   = 2;
  localparam int CPR  = COL / BS;
  localparam int SPB  = (CPR + NC - 1) / NC;
  localparam int NBLK = ROW / BS;
  localparam int WR_W  = (BS > 1) ? $clog2(BS) : 1;
  localparam int CB_W  = (CPR > 1) ? $clog2(CPR) : 1;
  localparam int BLK_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic slice_ready = 1'b0;
  logic in_ready, wr_en, slice_valid, busy, done;
  logic [WR_W-1:0]  wr_row;
  logic [CB_W-1:0]  chunk_base;
  logic [NC-1:0]    core_mask;
  logic [BLK_W-1:0] blk_idx;
`ifdef N2R_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  n2r_sched_ctrl #(.ROW(ROW), .COL(COL), .BLOCK_SIZE(BS), .NUM_CORES(NC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wr_en(wr_en),
    .wr_row(wr_row),
    .slice_valid(slice_valid),
    .slice_ready(slice_ready),
    .chunk_base(chunk_base),
    .core_mask(core_mask),
    .blk_idx(blk_idx),
    .busy(busy),
`ifdef N2R_SCHED_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .done(done)
  );

  typedef enum int {M_IDLE, M_FILL, M_DRAIN, M_DONE} mode_t;
  typedef struct {
    int blk;
    int base;
    int mask;
    bit last;
  } slice_t;

  int     checks = 0;
  int     failures = 0;
  mode_t  mode = M_IDLE;
  slice_t exp_q[$];
  int     exp_blk = 0;
  int     writes = 0;
  int     stall_model = 0;
  int     done_seen = 0;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic r);
    start       = s;
    in_valid    = v;
    slice_ready = r;
  endtask

  // Every slice of the matrix in issue order; the tail slice covers whatever chunks remain.
  task automatic buildMatrix();
    exp_q.delete();
    for (int b = 0; b < NBLK; b++) begin
      for (int s = 0; s < SPB; s++) begin
        slice_t sl;
        int nvalid;
        sl.blk  = b;
        sl.base = s * NC;
        nvalid  = CPR - sl.base;
        if (nvalid > NC) nvalid = NC;
        sl.mask = (1 << nvalid) - 1;
        sl.last = (s == SPB - 1);
        exp_q.push_back(sl);
      end
    end
  endtask

  // Compare this cycle's outputs against the model, then advance the model by one clock.
  task automatic modelCycle();
    slice_t cur;
    checkOutput("busy", busy, mode != M_IDLE);
    checkOutput("in_ready", in_ready, mode == M_FILL);
    checkOutput("slice_valid", slice_valid, mode == M_DRAIN);
    checkOutput("done", done, mode == M_DONE);
    checkOutput("wr_en", wr_en, in_valid && mode == M_FILL);
    case (mode)
      M_IDLE: begin
`ifdef N2R_SCHED_STALL_CNT_EN
        checkOutput("stall_cnt_hold", stall_cnt, stall_model);
`endif
        if (start) begin
          buildMatrix();
          mode        = M_FILL;
          exp_blk     = 0;
          writes      = 0;
          stall_model = 0;
        end
      end
      M_FILL: begin
        checkOutput("fill_blk_idx", blk_idx, exp_blk);
        if (in_valid) begin
          checkOutput("wr_row", wr_row, writes);
          writes++;
          if (writes == BS) begin
            writes = 0;
            mode   = M_DRAIN;
          end
        end
      end
      M_DRAIN: begin
        cur = exp_q[0];
        checkOutput("chunk_base", chunk_base, cur.base);
        checkOutput("core_mask", core_mask, cur.mask);
        checkOutput("drain_blk_idx", blk_idx, cur.blk);
        if (slice_ready) begin
          void'(exp_q.pop_front());
          if (cur.last) begin
            if (cur.blk == NBLK - 1) begin
              mode = M_DONE;
            end else begin
              mode = M_FILL;
              exp_blk++;
            end
          end
        end else begin
          stall_model++;
        end
      end
      M_DONE: begin
        done_seen++;
`ifdef N2R_SCHED_STALL_CNT_EN
        checkOutput("stall_cnt", stall_cnt, stall_model);
`endif
        mode = M_IDLE;
      end
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_slice_valid"}, slice_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_core_mask"}, core_mask, 0);
    checkOutput({tag, "_chunk_base"}, chunk_base, 0);
    checkOutput({tag, "_wr_row"}, wr_row, 0);
    checkOutput({tag, "_blk_idx"}, blk_idx, 0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      @(negedge clk);
      modelCycle();
    end
  endtask

  // Pattern 0: all handshakes high. 1: first slice stalled 3 cycles. 2: random handshakes
  // and stray start pulses. 3: in_valid toggling with start held high throughout.
  task automatic runMatrix(input int pattern, input bit abort_in_blk1_drain);
    int  d0;
    int  stall_left;
    bit  toggle;
    logic s, v, r;
    d0         = done_seen;
    stall_left = (pattern == 1) ? 3 : 0;
    toggle     = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    modelCycle();
    for (int cyc = 0; cyc < 400 && done_seen == d0; cyc++) begin
      @(posedge clk); #1;
      if (abort_in_blk1_drain && mode == M_DRAIN && exp_blk == 1) begin
        #1;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkResetOutputs("midrst");
        mode = M_IDLE;
        exp_q.delete();
        stall_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_no_done", done_seen, d0);
        return;
      end
      s = (pattern == 3) ? 1'b1 : ((pattern == 2) ? ($urandom_range(0, 4) == 0) : 1'b0);
      v = (pattern == 2) ? ($urandom_range(0, 2) != 0) : ((pattern == 3) ? toggle : 1'b1);
      toggle = ~toggle;
      if (pattern == 1 && mode == M_DRAIN && stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end else begin
        r = (pattern == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      applyStimulus(s, v, r);
      @(negedge clk);
      modelCycle();
    end
    if (abort_in_blk1_drain) begin
      checkOutput("reach_blk1_drain", 0, 1);
    end else begin
      checkOutput("matrix_done", done_seen, d0 + 1);
    end
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0);
    #12;
    checkResetOutputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2);
    runMatrix(0, 1'b0);
    idleCycles(2);
    runMatrix(1, 1'b0);
    idleCycles(2);
    runMatrix(3, 1'b0);
    idleCycles(2);
    for (int k = 0; k < 6; k++) begin
      runMatrix(2, 1'b0);
      idleCycles($urandom_range(1, 3));
    end
    runMatrix(0, 1'b1);
    idleCycles(3);
    runMatrix(2, 1'b1);
    idleCycles(2);
    runMatrix(0, 1'b0);
    idleCycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
